// File: rtl/dm_responder.sv
// dm_responder: memory-side responder for the core's load/store port.
// Accepts one request at a time, waits WAIT_CYCLES extra cycles, then
// performs a byte-enabled read or write on an internal word array and
// returns a one-cycle response. Committed stores also emit a trace record.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   req_we                 1 = store, 0 = load
//   req_addr               byte address (word index = addr[ADDR_WIDTH+1:2])
//   req_byteen             store byte-lane enables
//   req_wdata              lane-aligned store data
//   req_pc                 issuing PC, used for the trace record only
//   rsp_valid / rsp_rdata  one-cycle response; load data or merged store word
//   trace_valid            one-cycle pulse per store with nonzero byteen
//   trace_pc/addr/data     latched pc, word-aligned address, merged word
module dm_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  l_we;
    logic [ADDR_WIDTH-1:0] l_index;
    logic [3:0]            l_byteen;
    logic [31:0]           l_wdata;
    logic [31:0]           l_pc;

    logic [31:0] mem [DEPTH];
    logic [31:0] old_word;
    logic [31:0] merged;

    // Byte offset and bits above the array range do not select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

    assign req_ready = (state == IDLE);
    assign old_word  = mem[l_index];

    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (l_byteen[i]) merged[8*i +: 8] = l_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state       <= IDLE;
            cnt         <= '0;
            l_we        <= 1'b0;
            l_index     <= '0;
            l_byteen    <= '0;
            l_wdata     <= '0;
            l_pc        <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            trace_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we     <= req_we;
                        l_index  <= req_addr[ADDR_WIDTH+1:2];
                        l_byteen <= req_byteen;
                        l_wdata  <= req_wdata;
                        l_pc     <= req_pc;
                        cnt      <= 4'(WAIT_CYCLES);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // A zero-byteen store merges to the old word, so
                        // rsp_rdata needs no special case for it.
                        rsp_valid <= 1'b1;
                        rsp_rdata <= l_we ? merged : old_word;
                        if (l_we && (l_byteen != 4'd0)) begin
                            mem[l_index] <= merged;
                            trace_valid  <= 1'b1;
                            trace_pc     <= l_pc;
                            trace_addr   <= 32'({l_index, 2'b00});
                            trace_data   <= merged;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (WAIT_CYCLES 0, 3, 2) share all
// inputs; each phase resets and then exercises one instance's outputs.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;

    logic        ready [3];
    logic        rv    [3];
    logic [31:0] rd    [3];
    logic        tv    [3];
    logic [31:0] tpc   [3];
    logic [31:0] tad   [3];
    logic [31:0] tdat  [3];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_byteen(req_byteen),
        .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rv[0]),
        .rsp_rdata(rd[0]), .trace_valid(tv[0]), .trace_pc(tpc[0]),
        .trace_addr(tad[0]), .trace_data(tdat[0]));

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_byteen(req_byteen),
        .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rv[1]),
        .rsp_rdata(rd[1]), .trace_valid(tv[1]), .trace_pc(tpc[1]),
        .trace_addr(tad[1]), .trace_data(tdat[1]));

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_byteen(req_byteen),
        .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rv[2]),
        .rsp_rdata(rd[2]), .trace_valid(tv[2]), .trace_pc(tpc[2]),
        .trace_addr(tad[2]), .trace_data(tdat[2]));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] exp_rdata;
        logic        exp_trace;
        logic [31:0] exp_taddr;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one request on instance sel and check its response.
    task automatic run_vec(input int sel, input int wc, input vec_t v, input int idx);
        int  lat;
        bit  got;
        logic [31:0] r_rd, r_tpc, r_tad, r_tdat;
        logic        r_tv;
        @(negedge clk);
        chk($sformatf("ready_before[%0d]", idx), 32'(ready[sel]), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_byteen = v.be;
        req_wdata  = v.wdata;
        req_pc     = v.pc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        lat = 0;
        r_rd = '0; r_tv = 1'b0; r_tpc = '0; r_tad = '0; r_tdat = '0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (rv[sel]) begin
                got = 1; lat = n;
                r_rd = rd[sel]; r_tv = tv[sel];
                r_tpc = tpc[sel]; r_tad = tad[sel]; r_tdat = tdat[sel];
            end
        end
        if (!got) begin
            nchk++; nerr++;
            $display("FAIL rsp_timeout[%0d] actual=none expected=rsp_valid", idx);
            return;
        end
        chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(wc + 2));
        chk($sformatf("rdata[%0d]", idx), r_rd, v.exp_rdata);
        chk($sformatf("trace_valid[%0d]", idx), 32'(r_tv), 32'(v.exp_trace));
        if (v.exp_trace) begin
            chk($sformatf("trace_pc[%0d]", idx), r_tpc, v.pc);
            chk($sformatf("trace_addr[%0d]", idx), r_tad, v.exp_taddr);
            chk($sformatf("trace_data[%0d]", idx), r_tdat, v.exp_rdata);
        end
        @(negedge clk);
        chk($sformatf("rsp_pulse_end[%0d]", idx), 32'(rv[sel]), 32'd0);
        chk($sformatf("trace_pulse_end[%0d]", idx), 32'(tv[sel]), 32'd0);
    endtask

    initial begin
        vec_t ld;
        bit   exp_rsp, exp_rdy;
        int   nrsp;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_byteen = '0; req_wdata = '0; req_pc = '0;

        //          we    addr          be       wdata          pc             rdata          trace taddr
        vt[0]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_2000, 32'h0000_0000, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0000_3000, 32'h1234_5678, 1'b1, 32'h10};
        vt[2]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h0000_3004, 32'h1234_5678, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h0000_0012, 4'b0100, 32'h00AB_0000, 32'h0000_3008, 32'h12AB_5678, 1'b1, 32'h10};
        vt[4]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,         32'h0000_300C, 32'h12AB_5678, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0000_3010, 32'h12AB_5678, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h0000_3014, 32'h12AB_5678, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 32'h0000_4010, 4'hF, 32'hCAFE_0001, 32'h0000_3018, 32'hCAFE_0001, 1'b1, 32'h10};
        vt[8]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h0000_301C, 32'hCAFE_0001, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 32'h0000_0014, 4'b1001, 32'hAA00_00BB, 32'h0000_3020, 32'hAA00_00BB, 1'b1, 32'h14};
        vt[10] = '{1'b0, 32'h0000_8014, 4'h0, 32'h0,         32'h0000_3024, 32'hAA00_00BB, 1'b0, 32'h0};
        vt[11] = '{1'b1, 32'h0000_0015, 4'b0010, 32'h0000_CC00, 32'h0000_3028, 32'hAA00_CCBB, 1'b1, 32'h14};
        vt[12] = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,         32'h0000_302C, 32'hAA00_CCBB, 1'b0, 32'h0};

        // Reset state, sampled while reset is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_ready%0d", s), 32'(ready[s]), 32'd1);
            chk($sformatf("rst_rsp_valid%0d", s), 32'(rv[s]), 32'd0);
            chk($sformatf("rst_trace_valid%0d", s), 32'(tv[s]), 32'd0);
            chk($sformatf("rst_rdata%0d", s), rd[s], 32'd0);
            chk($sformatf("rst_tpc%0d", s), tpc[s], 32'd0);
            chk($sformatf("rst_taddr%0d", s), tad[s], 32'd0);
            chk($sformatf("rst_tdata%0d", s), tdat[s], 32'd0);
        end
        reset = 1'b0;

        // Table-driven vectors on the zero-wait instance.
        for (int i = 0; i < 13; i++) run_vec(0, 0, vt[i], i);

        // Wait states with req_valid held high across two requests.
        do_reset();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_byteen = 4'hF;
        req_wdata = 32'h1111_2222; req_pc = 32'h4000;
        chk("ws_ready_at_accept", 32'(ready[1]), 32'd1);
        @(posedge clk);
        nrsp = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            exp_rsp = (n == 5) || (n == 10);
            exp_rdy = !((n >= 1 && n <= 4) || (n >= 6 && n <= 9));
            chk($sformatf("ws_ready_n%0d", n), 32'(ready[1]), 32'(exp_rdy));
            chk($sformatf("ws_rsp_n%0d", n), 32'(rv[1]), 32'(exp_rsp));
            chk($sformatf("ws_trace_n%0d", n), 32'(tv[1]), 32'(n == 5));
            if (rv[1]) begin
                nrsp++;
                chk($sformatf("ws_rdata_n%0d", n), rd[1], 32'h1111_2222);
            end
            if (n == 5) begin
                req_we = 1'b0; req_byteen = 4'h0; req_wdata = 32'hFFFF_FFFF;
            end
            if (n == 6) req_valid = 1'b0;
        end
        chk("ws_total_responses", 32'(nrsp), 32'd2);

        // Reset one cycle after accepting a store drops it entirely.
        do_reset();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_byteen = 4'hF;
        req_wdata = 32'hDEAD_BEEF; req_pc = 32'h5000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        for (int n = 2; n <= 8; n++) begin
            @(negedge clk);
            if (n == 3) reset = 1'b0;
            chk($sformatf("mid_rst_rsp_n%0d", n), 32'(rv[2]), 32'd0);
            chk($sformatf("mid_rst_trace_n%0d", n), 32'(tv[2]), 32'd0);
        end
        ld = '{1'b0, 32'h20, 4'h0, 32'h0, 32'h5004, 32'h0, 1'b0, 32'h0};
        run_vec(2, 2, ld, 100);

        // Reset wins over a simultaneous request.
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_byteen = 4'hF; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        chk("rst_prio_ready", 32'(ready[2]), 32'd1);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk($sformatf("rst_prio_rsp_n%0d", n), 32'(rv[2]), 32'd0);
        end
        run_vec(2, 2, ld, 101);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
